// File: rtl/regfile_pkg.sv
// Shared widths, types and constants for the scoreboarded integer register file.
package regfile_pkg;

  localparam int unsigned REG_WIDTH_DEFAULT  = 32;
  localparam int unsigned ADDR_WIDTH_DEFAULT = 5;

  typedef logic [REG_WIDTH_DEFAULT-1:0]  reg_data_t;
  typedef logic [ADDR_WIDTH_DEFAULT-1:0] reg_addr_t;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard: WAW issue refusal and an incremental pending-producer count.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic             issue_valid_i,
  input  logic [AW-1:0]    issue_reg_i,
  output logic [DEPTH-1:0] busy_o,
  output logic             conflict_o,
  output logic [AW:0]      pending_o
);

  localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);
  localparam logic [AW:0]   CountOne = (AW+1)'(1);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;
  logic             clear, set, inc, dec, conflict;

  always_comb begin
    clear    = wr_en_i && (wr_addr_i != ZeroAddr);
    // A writeback to the same register this cycle frees the slot for the new producer.
    conflict = issue_valid_i && busy_q[issue_reg_i] && !(wr_en_i && (wr_addr_i == issue_reg_i));
    set      = issue_valid_i && !conflict && (issue_reg_i != ZeroAddr);

    busy_d = busy_q;
    if (clear) busy_d[wr_addr_i] = 1'b0;
    if (set)   busy_d[issue_reg_i] = 1'b1;
    busy_d[0] = 1'b0;

    inc = set && !busy_q[issue_reg_i];
    dec = clear && busy_q[wr_addr_i] && !(set && (issue_reg_i == wr_addr_i));

    count_d = count_q;
    if (inc && !dec) begin
      count_d = count_q + CountOne;
    end else if (dec && !inc) begin
      count_d = count_q - CountOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o     = busy_q;
  assign conflict_o = conflict;
  assign pending_o  = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read, single-write register file (x0 hard-wired to zero) with busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned REG_WIDTH          = REG_WIDTH_DEFAULT,
  parameter  int unsigned DEPTH              = 32,
  parameter  int unsigned NUM_READ           = 2,
  localparam int unsigned ADDRESS_PORT_WIDTH = $clog2(DEPTH)
) (
  input  logic                                         CLK,
  input  logic                                         Reset,
  input  logic [NUM_READ-1:0][ADDRESS_PORT_WIDTH-1:0]  ReadReg,
  output logic [NUM_READ-1:0][REG_WIDTH-1:0]           ReadData,
  output logic [NUM_READ-1:0]                          ReadBusy,
  input  logic                                         RegWrite,
  input  logic [ADDRESS_PORT_WIDTH-1:0]                WriteAddress,
  input  logic [REG_WIDTH-1:0]                         WriteData,
  input  logic                                         IssueValid,
  input  logic [ADDRESS_PORT_WIDTH-1:0]                IssueReg,
  output logic                                         IssueConflict,
  output logic [ADDRESS_PORT_WIDTH:0]                  PendingCount
);

  localparam logic [ADDRESS_PORT_WIDTH-1:0] ZeroAddr = ADDRESS_PORT_WIDTH'(ZERO_REG);

  logic [REG_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]     busy;
  logic                 wr_hit;

  assign wr_hit = RegWrite && (WriteAddress != ZeroAddr);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[WriteAddress] <= WriteData;
    end
  end

  regfile_busy_tracker #(
    .DEPTH (DEPTH)
  ) u_busy_tracker (
    .clk_i         (CLK),
    .rst_ni        (Reset),
    .wr_en_i       (RegWrite),
    .wr_addr_i     (WriteAddress),
    .issue_valid_i (IssueValid),
    .issue_reg_i   (IssueReg),
    .busy_o        (busy),
    .conflict_o    (IssueConflict),
    .pending_o     (PendingCount)
  );

  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      ReadData[i] = '0;
      ReadBusy[i] = busy[ReadReg[i]];
      if (ReadReg[i] != ZeroAddr) ReadData[i] = regs_q[ReadReg[i]];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (ReadReg[i] == WriteAddress)) begin
        ReadData[i] = WriteData;
        ReadBusy[i] = 1'b0;
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (three read ports).
module tb_regfile_scoreboard;

  localparam int unsigned RW = 32;
  localparam int unsigned NR = 3;
  localparam int unsigned AW = 5;

  logic                        CLK = 1'b0;
  logic                        Reset;
  logic [NR-1:0][AW-1:0]       ReadReg;
  logic [NR-1:0][RW-1:0]       ReadData;
  logic [NR-1:0]               ReadBusy;
  logic                        RegWrite;
  logic [AW-1:0]               WriteAddress;
  logic [RW-1:0]               WriteData;
  logic                        IssueValid;
  logic [AW-1:0]               IssueReg;
  logic                        IssueConflict;
  logic [AW:0]                 PendingCount;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_scoreboard #(
    .REG_WIDTH (RW),
    .DEPTH     (32),
    .NUM_READ  (NR)
  ) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .ReadReg       (ReadReg),
    .ReadData      (ReadData),
    .ReadBusy      (ReadBusy),
    .RegWrite      (RegWrite),
    .WriteAddress  (WriteAddress),
    .WriteData     (WriteData),
    .IssueValid    (IssueValid),
    .IssueReg      (IssueReg),
    .IssueConflict (IssueConflict),
    .PendingCount  (PendingCount)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RegWrite     = 1'b0;
    WriteAddress = '0;
    WriteData    = '0;
    IssueValid   = 1'b0;
    IssueReg     = '0;
  endtask

  task automatic read_all(input logic [AW-1:0] r);
    for (int p = 0; p < NR; p++) ReadReg[p] = r;
  endtask

  initial begin
    Reset   = 1'b0;
    ReadReg = '0;
    idle();

    // 1. reset, then sweep every register on all ports
    step();
    Reset = 1'b1;
    #1;
    check_eq("rst_pending", 64'(PendingCount), 64'd0);
    check_eq("rst_conflict", 64'(IssueConflict), 64'd0);
    for (int r = 0; r < 32; r++) begin
      read_all(AW'(r));
      #1;
      for (int p = 0; p < NR; p++) check_eq("rst_data", 64'(ReadData[p]), 64'd0);
      check_eq("rst_busy", 64'(ReadBusy), 64'd0);
    end

    // 2. write x1, x2 and read from three ports
    RegWrite = 1'b1; WriteAddress = 5'd1; WriteData = 32'hAAAA_BBBB;
    step();
    WriteAddress = 5'd2; WriteData = 32'h1234_5678;
    step();
    idle();
    ReadReg[0] = 5'd1; ReadReg[1] = 5'd2; ReadReg[2] = 5'd1;
    #1;
    check_eq("rd_p0_x1", 64'(ReadData[0]), 64'hAAAA_BBBB);
    check_eq("rd_p1_x2", 64'(ReadData[1]), 64'h1234_5678);
    check_eq("rd_p2_x1", 64'(ReadData[2]), 64'hAAAA_BBBB);

    // 3. write to x0 and issue x0 are both no-ops
    RegWrite = 1'b1; WriteAddress = 5'd0; WriteData = 32'hDEAD_BEEF;
    IssueValid = 1'b1; IssueReg = 5'd0;
    #1;
    check_eq("x0_issue_conflict", 64'(IssueConflict), 64'd0);
    step();
    idle();
    read_all(5'd0);
    #1;
    check_eq("x0_data", 64'(ReadData[0]), 64'd0);
    check_eq("x0_busy", 64'(ReadBusy), 64'd0);
    check_eq("x0_pending", 64'(PendingCount), 64'd0);

    // 4. issue x5, refused re-issue, writeback clears
    IssueValid = 1'b1; IssueReg = 5'd5;
    #1;
    check_eq("x5_issue_ok", 64'(IssueConflict), 64'd0);
    step();
    IssueValid = 1'b0;
    read_all(5'd5);
    #1;
    check_eq("x5_busy", 64'(ReadBusy[0]), 64'd1);
    check_eq("x5_pending1", 64'(PendingCount), 64'd1);
    IssueValid = 1'b1; IssueReg = 5'd5;
    #1;
    check_eq("x5_waw_conflict", 64'(IssueConflict), 64'd1);
    step();
    check_eq("x5_refused_pending", 64'(PendingCount), 64'd1);
    check_eq("x5_refused_busy", 64'(ReadBusy[1]), 64'd1);
    idle();
    RegWrite = 1'b1; WriteAddress = 5'd5; WriteData = 32'h5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("x5_wb_cycle_data", 64'(ReadData[0]), 64'h5);
    check_eq("x5_wb_cycle_busy", 64'(ReadBusy[0]), 64'd0);
`else
    check_eq("x5_wb_cycle_data", 64'(ReadData[0]), 64'h0);
    check_eq("x5_wb_cycle_busy", 64'(ReadBusy[0]), 64'd1);
`endif
    step();
    idle();
    #1;
    check_eq("x5_after_data", 64'(ReadData[2]), 64'h5);
    check_eq("x5_after_busy", 64'(ReadBusy), 64'd0);
    check_eq("x5_after_pending", 64'(PendingCount), 64'd0);

    // 5. issue x5 again, then writeback and re-issue in the same cycle
    IssueValid = 1'b1; IssueReg = 5'd5;
    step();
    check_eq("x5_reissue_pending", 64'(PendingCount), 64'd1);
    RegWrite = 1'b1; WriteAddress = 5'd5; WriteData = 32'h55;
    #1;
    check_eq("x5_wb_issue_conflict", 64'(IssueConflict), 64'd0);
    step();
    idle();
    #1;
    check_eq("x5_set_wins_busy", 64'(ReadBusy[0]), 64'd1);
    check_eq("x5_set_wins_pending", 64'(PendingCount), 64'd1);
    check_eq("x5_set_wins_data", 64'(ReadData[0]), 64'h55);
    // clearing a register that is not busy leaves the count alone
    RegWrite = 1'b1; WriteAddress = 5'd6; WriteData = 32'h66;
    step();
    idle();
    check_eq("clear_idle_pending", 64'(PendingCount), 64'd1);
    RegWrite = 1'b1; WriteAddress = 5'd5; WriteData = 32'h55;
    step();
    idle();
    check_eq("x5_drain_pending", 64'(PendingCount), 64'd0);

    // 6. issue x3, x4, x7 then reset with a write to x3 pending
    IssueValid = 1'b1;
    IssueReg = 5'd3; step();
    IssueReg = 5'd4; step();
    IssueReg = 5'd7; step();
    idle();
    check_eq("three_pending", 64'(PendingCount), 64'd3);
    ReadReg[0] = 5'd3; ReadReg[1] = 5'd4; ReadReg[2] = 5'd7;
    #1;
    check_eq("three_busy", 64'(ReadBusy), 64'b111);
    Reset = 1'b0;
    RegWrite = 1'b1; WriteAddress = 5'd3; WriteData = 32'h3333_3333;
    IssueValid = 1'b1; IssueReg = 5'd9;
    step();
    Reset = 1'b1;
    idle();
    #1;
    check_eq("post_rst_pending", 64'(PendingCount), 64'd0);
    check_eq("post_rst_busy", 64'(ReadBusy), 64'd0);
    check_eq("post_rst_x3", 64'(ReadData[0]), 64'd0);
    read_all(5'd1);
    #1;
    check_eq("post_rst_x1", 64'(ReadData[1]), 64'd0);
    read_all(5'd9);
    #1;
    check_eq("post_rst_x9_busy", 64'(ReadBusy), 64'd0);
    IssueValid = 1'b1; IssueReg = 5'd3;
    #1;
    check_eq("post_rst_conflict", 64'(IssueConflict), 64'd0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the single-write, two-read integer register file. It provides NUM_READ combinational read ports and one synchronous write port, with register 0 hard-wired to zero. A per-register busy scoreboard tracks in-flight producers for pipeline hazard detection. It sits in the RV32I datapath between decode/issue and writeback, and feeds the stall logic.

Parameters:
- REG_WIDTH, 32: data width of each register.
- DEPTH, 32: number of architectural registers; power of two, >= 2.
- NUM_READ, 2: number of independent read ports, 1..4.
- ADDRESS_PORT_WIDTH, $clog2(DEPTH): register index width; derived, not overridden.

Ports:
- CLK, in, 1: single clock; all state updates on its rising edge.
- Reset, in, 1: synchronous, active-low reset; sampled on the CLK rising edge.
- ReadReg, in, NUM_READ x ADDRESS_PORT_WIDTH: read address per port.
- ReadData, out, NUM_READ x REG_WIDTH: read data per port; combinational.
- ReadBusy, out, NUM_READ: the addressed register has a pending producer.
- RegWrite, in, 1: write enable.
- WriteAddress, in, ADDRESS_PORT_WIDTH: write target.
- WriteData, in, REG_WIDTH: write value.
- IssueValid, in, 1: an instruction with destination IssueReg is issuing this cycle.
- IssueReg, in, ADDRESS_PORT_WIDTH: destination register of the issuing instruction.
- IssueConflict, out, 1: the issue is refused because of a WAW hazard; combinational.
- PendingCount, out, ADDRESS_PORT_WIDTH+1: number of busy registers.

Behaviour:
- Reset
  - Reset==0 at a rising edge clears all registers, all busy bits and PendingCount to 0.
  - Reset has priority over write and issue in the same cycle.
  - After reset, every ReadData is 0, every ReadBusy is 0 and IssueConflict is 0 (when IssueValid==0).
  - Reset asserted mid-operation discards all pending state; there is no partial completion.
- Write
  - At a rising edge, if RegWrite==1 and WriteAddress!=0, then regs[WriteAddress] <= WriteData.
  - Writes to register 0 are dropped.
- Read
  - Zero-cycle latency.
  - ReadData[i] = 0 if ReadReg[i]==0; otherwise regs[ReadReg[i]], or the bypass value (see Optional Feature).
  - All ports are independent; any number of ports may address the same register.
- Scoreboard
  - There is one busy bit per register, and busy[0] is always 0.
  - Clear: at a rising edge, RegWrite==1 with WriteAddress!=0 clears busy[WriteAddress].
  - IssueConflict = IssueValid && busy[IssueReg] && !(RegWrite && WriteAddress==IssueReg).
  - Set: an accepted issue (IssueValid && !IssueConflict && IssueReg!=0) sets busy[IssueReg].
  - Same register cleared and set in one cycle: the set wins, so the bit stays 1.
  - A refused issue changes no state; the issuer holds IssueValid and IssueReg and retries.
  - An issue with IssueReg==0 is always accepted and has no effect.
  - ReadBusy[i] = busy[ReadReg[i]], qualified by the bypass rule below.
- PendingCount
  - Incremental update: +1 on a set of a not-busy bit, -1 on a clear of a busy bit, net 0 when both occur.
  - It must always equal the popcount of the busy vector.
  - A clear of an already-clear bit leaves the count unchanged.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When RegWrite==1, WriteAddress!=0 and ReadReg[i]==WriteAddress, ReadData[i] = WriteData in the same cycle.
  - In that case ReadBusy[i] = 0.
- Undefined:
  - ReadData[i] returns the stored value, so new data is visible the cycle after the write edge.
  - ReadBusy[i] stays 1 until the clear edge.

Decomposition:
- Package regfile_pkg holds:
  - the REG_WIDTH and ADDRESS_PORT_WIDTH defaults;
  - the typedefs reg_data_t and reg_addr_t;
  - the constant ZERO_REG = 0.
- One sub-module, regfile_busy_tracker: owns the busy vector, the IssueConflict logic and PendingCount.
- The top level owns the storage array and the read/bypass muxes.

Test Plan:
1. Reset low for 1 edge, then read every register on all ports -> ReadData all 0, ReadBusy 0, PendingCount 0.
2. Write x1=32'hAAAA_BBBB and x2=32'h1234_5678, then ReadReg={1,2,1} -> 32'hAAAA_BBBB, 32'h1234_5678, 32'hAAAA_BBBB.
3. Write x0=32'hDEADBEEF and issue IssueReg=0 -> reading x0 gives 0; PendingCount stays 0.
4. Issue x5 -> PendingCount 1 and ReadBusy=1 on x5. Next cycle issue x5 again -> IssueConflict=1, count stays 1. Write x5=32'h5 -> busy clears and count returns to 0. With REGFILE_BYPASS_EN, the read of x5 on the write cycle returns 32'h5 with ReadBusy=0.
5. Same cycle as the x5 writeback, issue x5 -> IssueConflict=0, busy[x5] stays 1, PendingCount unchanged at 1.
6. Issue x3, x4, x7 -> PendingCount 3. Assert Reset mid-sequence while RegWrite=1 to x3 -> everything reads 0, PendingCount 0, x3 is not written.
